// File: rtl/lamp_pkg.sv
// Shared encodings for the lamp sequence checker: lamp codes, tracked colour
// states, error codes and colour decode/successor helpers.
package lamp_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b001;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_RED    = 2'd1,
    ST_GREEN  = 2'd2,
    ST_YELLOW = 2'd3
  } lamp_state_t;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_ILLEGAL     = 3'd1,
    ERR_TRANSITION  = 3'd2,
    ERR_DWELL_SHORT = 3'd3,
    ERR_DWELL_LONG  = 3'd4
  } lamp_err_t;

  // Non-one-hot codes decode to ST_UNSYNC.
  function automatic lamp_state_t decode_light(input logic [2:0] l);
    case (l)
      LIGHT_RED:    return ST_RED;
      LIGHT_GREEN:  return ST_GREEN;
      LIGHT_YELLOW: return ST_YELLOW;
      default:      return ST_UNSYNC;
    endcase
  endfunction

  function automatic lamp_state_t successor(input lamp_state_t s);
    case (s)
      ST_RED:    return ST_GREEN;
      ST_GREEN:  return ST_YELLOW;
      ST_YELLOW: return ST_RED;
      default:   return ST_UNSYNC;
    endcase
  endfunction

endpackage

// File: rtl/lamp_dwell_counter.sv
// Per-visit dwell counter, saturating at MAX_DWELL+1, with the bound compares
// used for the short/long dwell errors.
module lamp_dwell_counter #(
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic restart,
  input  logic hold,
  output logic dwell_short,
  output logic dwell_at_max
);

  localparam int unsigned DW = $clog2(MAX_DWELL + 2);
  localparam logic [DW-1:0] SAT = DW'(MAX_DWELL + 1);

  logic [DW-1:0] dwell_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else if (flush) begin
      dwell_q <= '0;
    end else if (restart) begin
      dwell_q <= DW'(1);
    end else if (hold && dwell_q != SAT) begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  // At MAX the next hold lands on MAX+1; saturation keeps the long error one-shot.
  assign dwell_short  = 32'(dwell_q) < MIN_DWELL;
  assign dwell_at_max = dwell_q == DW'(MAX_DWELL);

endmodule

// File: rtl/lamp_sequence_checker.sv
// Traffic-lamp sequence checker: tracks RED->GREEN->YELLOW, flags illegal codes,
// transitions and (with LAMP_DWELL_CHECK_EN defined) dwell violations.
module lamp_sequence_checker
  import lamp_pkg::*;
#(
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       light,
  output logic [1:0]       state,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] cycle_count
);

  if (MAX_DWELL < MIN_DWELL) begin : g_cfg_check
    $error("lamp_sequence_checker: MAX_DWELL must not be below MIN_DWELL");
  end

  lamp_state_t      state_q, state_d, obs;
  lamp_err_t        err_d, err_q;
  logic             err_valid_q;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             armed_q, armed_d;
  logic             checked_q, checked_d;
  logic             bad_code, bad_trans, legal_step, hold;
  logic             short_err, long_err, count_inc;
  logic             dwell_short, dwell_at_max;

`ifdef LAMP_DWELL_CHECK_EN
  lamp_dwell_counter #(
    .MIN_DWELL (MIN_DWELL),
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (bad_code),
    .restart      (!bad_code && !hold),
    .hold         (hold),
    .dwell_short  (dwell_short),
    .dwell_at_max (dwell_at_max)
  );
`else
  assign dwell_short  = 1'b0;
  assign dwell_at_max = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_UNSYNC;
      err_q         <= ERR_NONE;
      err_valid_q   <= 1'b0;
      cycle_count_q <= '0;
      armed_q       <= 1'b0;
      checked_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      err_valid_q   <= err_d != ERR_NONE;
      cycle_count_q <= cycle_count_d;
      armed_q       <= armed_d;
      checked_q     <= checked_d;
    end
  end

  // armed: the current visit was reached from a RED by an unbroken legal chain,
  // so a clean YELLOW->RED completes a full cycle.
  always_comb begin
    obs        = decode_light(light);
    state_d    = state_q;
    armed_d    = armed_q;
    checked_d  = checked_q;
    bad_code   = 1'b0;
    bad_trans  = 1'b0;
    legal_step = 1'b0;
    hold       = 1'b0;
    if (obs == ST_UNSYNC) begin
      bad_code  = 1'b1;
      state_d   = ST_UNSYNC;
      armed_d   = 1'b0;
      checked_d = 1'b0;
    end else if (state_q == ST_UNSYNC) begin
      state_d   = obs;
      armed_d   = 1'b0;
      checked_d = 1'b0;
    end else if (obs == state_q) begin
      hold = 1'b1;
    end else if (obs == successor(state_q)) begin
      legal_step = 1'b1;
      state_d    = obs;
      checked_d  = 1'b1;
      case (state_q)
        ST_RED:   armed_d = 1'b1;
        ST_GREEN: armed_d = armed_q;
        default:  armed_d = 1'b0;
      endcase
    end else begin
      bad_trans = 1'b1;
      state_d   = obs;
      armed_d   = 1'b0;
      checked_d = 1'b0;
    end
  end

  always_comb begin
    short_err = legal_step && checked_q && dwell_short;
    long_err  = hold && checked_q && dwell_at_max;
    err_d     = ERR_NONE;
    if (bad_code)       err_d = ERR_ILLEGAL;
    else if (bad_trans) err_d = ERR_TRANSITION;
    else if (short_err) err_d = ERR_DWELL_SHORT;
    else if (long_err)  err_d = ERR_DWELL_LONG;
    count_inc     = legal_step && state_q == ST_YELLOW && armed_q && !short_err;
    cycle_count_d = cycle_count_q;
    if (count_inc && cycle_count_q != '1) cycle_count_d = cycle_count_q + 1'b1;
  end

  assign state       = state_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: doc/lamp_sequence_checker.md
LAMP_SEQUENCE_CHECKER -- requirements
Module: lamp_sequence_checker

Interface
REQ-001 Parameter MIN_DWELL, default 1, minimum legal cycles a colour is held.
REQ-002 Parameter MAX_DWELL, default 1, maximum legal cycles a colour is held.
REQ-003 Parameter CNT_W, default 8, width of cycle_count.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 light  input  3  observed lamp, {R,G,Y}; legal codes 3'b100 RED, 3'b010 GREEN, 3'b001 YELLOW.
REQ-007 state  output  2  tracked colour: 0 UNSYNC, 1 RED, 2 GREEN, 3 YELLOW.
REQ-008 err_valid  output  1  one-cycle error pulse.
REQ-009 err_code  output  3  0 none, 1 illegal code, 2 illegal transition, 3 dwell short, 4 dwell long; valid with err_valid, else 0.
REQ-010 cycle_count  output  CNT_W  completed RED->GREEN->YELLOW->RED cycles.

Function
REQ-011 light SHALL be sampled every rising clk; all outputs SHALL be registered, reflecting sample N at edge N+1.
REQ-012 From UNSYNC, the first legal code SHALL move state to that colour, with no error and the dwell counter set to 1.
REQ-013 A non-one-hot code (000, 011, 101, 110, 111) SHALL raise err_code 1 and force UNSYNC, from any state.
REQ-014 Legal transitions SHALL be RED->GREEN, GREEN->YELLOW and YELLOW->RED only; same colour is a hold.
REQ-015 Any other colour change (e.g. RED->YELLOW) SHALL raise err_code 2 and resync state to the observed colour, with dwell 1.
REQ-016 The dwell counter SHALL increment on each hold and saturate at MAX_DWELL+1.
REQ-017 On a legal transition with dwell < MIN_DWELL, the checker SHALL raise err_code 3 and still advance.
REQ-018 Dwell reaching MAX_DWELL+1 SHALL raise err_code 4 exactly once per colour visit.
REQ-019 Simultaneous error conditions SHALL report only the lowest nonzero code; cycle_count SHALL increment only on legal YELLOW->RED without error.
REQ-020 cycle_count SHALL saturate at all-ones and never wrap.
REQ-021 Dwell errors apply only to visits entered by a legal transition, never to the first colour after UNSYNC.

Reset
REQ-022 While rst_n is low: state=UNSYNC, err_valid=0, err_code=0, cycle_count=0, dwell=0, asynchronously.
REQ-023 Reset asserted mid-visit SHALL discard dwell and the partial cycle; after release, checking SHALL resume per REQ-012.

Configuration
REQ-024 With LAMP_DWELL_CHECK_EN defined, the dwell counter and codes 3/4 SHALL be present.
REQ-025 Without LAMP_DWELL_CHECK_EN, the dwell logic SHALL be absent, codes 3/4 SHALL never be produced, and MIN_DWELL/MAX_DWELL SHALL be ignored.

Structure
REQ-026 Package lamp_pkg SHALL hold the colour encodings, state encodings and err_code constants.
REQ-027 The dwell counter and its bound compare SHALL be sub-module lamp_dwell_counter, instantiated only under LAMP_DWELL_CHECK_EN.

Verification
REQ-028 Defaults, light 100,010,001 repeated 4x, one cycle each -> no err_valid, cycle_count=3, state tracks colour one cycle late.
REQ-029 light 100,010,110,010 -> err_code 1 at the edge after 110, state UNSYNC, then GREEN with no error.
REQ-030 light 100,001 -> err_code 2, state YELLOW; next 100 is legal, no cycle_count increment.
REQ-031 MIN_DWELL=2, MAX_DWELL=3: RED x1 then GREEN -> code 3. GREEN x4 -> code 4 once only, even if GREEN is held x10.
REQ-032 rst_n low mid-GREEN for 1 cycle with cycle_count=2 -> all outputs 0 immediately; next 001 syncs YELLOW without error.
REQ-033 CNT_W=2, 5 clean cycles -> cycle_count sticks at 3; build without macro plus REQ-031 stimulus -> no err_valid.
